// File: rtl/servo_ramp_ctrl.sv
// Slew-rate limiter in front of the two-channel Servo block: steps each 12-bit
// channel toward its target by at most STEP per tick and issues one write per step.
module servo_ramp_ctrl #(
  parameter int          TICK_DIV = 50000,
  parameter int          STEP     = 4,
  parameter logic [11:0] INIT_POS = 12'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] tgt_data,
  input  logic        tgt_wr,
  output logic [23:0] servo_data,
  output logic        servo_wr,
  output logic [23:0] cur_pos,
  output logic        busy
);

  localparam int          CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [12:0] STEP_W    = 13'(STEP);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    RAMP  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] count_r;
  logic          tick_s;
  logic [11:0]   cur0_r;
  logic [11:0]   cur1_r;
  logic [11:0]   tgt0_r;
  logic [11:0]   tgt1_r;
  logic [11:0]   step0_s;
  logic [11:0]   step1_s;
  logic [23:0]   tgt_next_s;
  logic          step_en_s;
  logic          wr_s;
  logic [23:0]   servo_data_r;
  logic          servo_wr_r;
  logic          busy_s;

  // One bounded step toward the target; the difference is taken 13 bits wide so it never wraps.
  function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
    logic [12:0] d;
    logic [12:0] mag;
    d   = {1'b0, tgt} - {1'b0, cur};
    mag = d[12] ? (13'd0 - d) : d;
    if (mag <= STEP_W) begin
      return tgt;
    end else if (d[12]) begin
      return cur - STEP_W[11:0];
    end else begin
      return cur + STEP_W[11:0];
    end
  endfunction

  assign tick_s     = (count_r == TICK_LAST);
  assign busy_s     = ({cur1_r, cur0_r} != {tgt1_r, tgt0_r});
  assign tgt_next_s = tgt_wr ? tgt_data : {tgt1_r, tgt0_r};
  assign step0_s    = step_toward(cur0_r, tgt0_r);
  assign step1_s    = step_toward(cur1_r, tgt1_r);

  assign servo_data = servo_data_r;
  assign servo_wr   = servo_wr_r;
  assign cur_pos    = {cur1_r, cur0_r};
  assign busy       = busy_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SYNC;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and step/write decisions; WRITE exits against a target latched in the same cycle.
  always_comb begin
    next_state_s = state_r;
    step_en_s    = 1'b0;
    wr_s         = 1'b0;
    case (state_r)
      SYNC: begin
        next_state_s = IDLE;
        wr_s         = 1'b1;
      end
      IDLE: begin
        if (busy_s) begin
          next_state_s = RAMP;
        end else begin
          next_state_s = IDLE;
        end
      end
      RAMP: begin
        if (!busy_s) begin
          next_state_s = IDLE;
        end else if (tick_s) begin
          next_state_s = WRITE;
          step_en_s    = 1'b1;
          wr_s         = 1'b1;
        end else begin
          next_state_s = RAMP;
        end
      end
      WRITE: begin
        if ({cur1_r, cur0_r} == tgt_next_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RAMP;
        end
      end
      default: begin
        next_state_s = SYNC;
      end
    endcase
  end

  // Tick counter, target latch, channel positions and the registered Servo write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r      <= '0;
      cur0_r       <= INIT_POS;
      cur1_r       <= INIT_POS;
      tgt0_r       <= INIT_POS;
      tgt1_r       <= INIT_POS;
      servo_data_r <= {INIT_POS, INIT_POS};
      servo_wr_r   <= 1'b0;
    end else begin
      count_r    <= tick_s ? '0 : count_r + CW'(1);
      servo_wr_r <= wr_s;
      if (tgt_wr) begin
        tgt0_r <= tgt_data[11:0];
        tgt1_r <= tgt_data[23:12];
      end
      if (step_en_s) begin
        cur0_r       <= step0_s;
        cur1_r       <= step1_s;
        servo_data_r <= {step1_s, step0_s};
      end
    end
  end

endmodule
